// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite slave register bank.
// Registers 0..N-2 are read/write with byte strobes; register N-1 is a
// read-only count of completed OKAY writes. AW and W may arrive in either
// order or together; the write response follows the final handshake by one
// cycle. The read path is independent of the write path.
module axi4lite_slave_regfile #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  // write address channel
  input  logic [ADDR_WIDTH-1:0]                  s_awaddr,
  input  logic                                   s_awvalid,
  output logic                                   s_awready,
  // write data channel
  input  logic [DATA_WIDTH-1:0]                  s_wdata,
  input  logic [DATA_WIDTH/8-1:0]                s_wstrb,
  input  logic                                   s_wvalid,
  output logic                                   s_wready,
  // write response channel
  output logic [1:0]                             s_bresp,
  output logic                                   s_bvalid,
  input  logic                                   s_bready,
  // read address channel
  input  logic [ADDR_WIDTH-1:0]                  s_araddr,
  input  logic                                   s_arvalid,
  output logic                                   s_arready,
  // read data channel
  output logic [DATA_WIDTH-1:0]                  s_rdata,
  output logic [1:0]                             s_rresp,
  output logic                                   s_rvalid,
  input  logic                                   s_rready,
  // live register contents, register k at [k*DATA_WIDTH +: DATA_WIDTH]
  output logic [((2**ADDR_WIDTH)-1)*DATA_WIDTH-1:0] reg_out
);

  localparam int N      = 2 ** ADDR_WIDTH;
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = ADDR_WIDTH'(N - 1);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  // Write-side progress: which halves of the transaction are already held,
  // or whether a response is waiting for the master.
  typedef enum logic [1:0] {
    WR_IDLE = 2'b00,  // nothing held
    WR_ADDR = 2'b01,  // address held, waiting for data
    WR_DATA = 2'b10,  // data held, waiting for address
    WR_RESP = 2'b11   // response pending
  } wr_state_t;

  wr_state_t wr_state, wr_state_nxt;

  logic [DATA_WIDTH-1:0] regs [N-1];
  logic [DATA_WIDTH-1:0] wr_count;

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [1:0]            bresp_q;

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [DATA_WIDTH-1:0] eff_data;
  logic [STRB_W-1:0]     eff_strb;
  logic                  eff_is_cnt;
  logic [DATA_WIDTH-1:0] rd_word;

  // ---------------------------------------------------------------------------
  // Handshakes. Readies depend on state only, never on an incoming valid.
  // ---------------------------------------------------------------------------
  assign s_awready = (wr_state == WR_IDLE) || (wr_state == WR_DATA);
  assign s_wready  = (wr_state == WR_IDLE) || (wr_state == WR_ADDR);
  assign s_bvalid  = (wr_state == WR_RESP);
  assign s_bresp   = bresp_q;

  assign s_arready = !rvalid_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = RESP_OKAY;

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid  && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  // The half that arrived earlier comes from its holding register, the half
  // completing on this edge comes straight from the bus.
  assign eff_addr   = (wr_state == WR_ADDR) ? aw_addr_q : s_awaddr;
  assign eff_data   = (wr_state == WR_DATA) ? w_data_q  : s_wdata;
  assign eff_strb   = (wr_state == WR_DATA) ? w_strb_q  : s_wstrb;
  assign eff_is_cnt = (eff_addr == CNT_ADDR);

  // ---------------------------------------------------------------------------
  // Write FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every clocked process uses non-blocking assignments so all
    // flops sample pre-edge values regardless of process ordering.
    if (!rst_n) wr_state <= WR_IDLE;
    else        wr_state <= wr_state_nxt;
  end

  // Write FSM: next state and the commit strobe.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    wr_state_nxt = wr_state;
    commit       = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_nxt = WR_RESP;
          commit       = 1'b1;
        end else if (aw_hs) begin
          wr_state_nxt = WR_ADDR;
        end else if (w_hs) begin
          wr_state_nxt = WR_DATA;
        end
      end
      WR_ADDR: begin
        if (w_hs) begin
          wr_state_nxt = WR_RESP;
          commit       = 1'b1;
        end
      end
      WR_DATA: begin
        if (aw_hs) begin
          wr_state_nxt = WR_RESP;
          commit       = 1'b1;
        end
      end
      WR_RESP: begin
        if (s_bready) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Hold whichever half of a write arrives first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= s_awaddr;
      if (w_hs) begin
        w_data_q <= s_wdata;
        w_strb_q <= s_wstrb;
      end
    end
  end

  // Write response code: set at commit, cleared once the master takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bresp_q <= RESP_OKAY;
    end else if (commit) begin
      bresp_q <= eff_is_cnt ? RESP_SLVERR : RESP_OKAY;
    end else if (s_bvalid && s_bready) begin
      bresp_q <= RESP_OKAY;
    end
  end

  // Register array update with byte strobes; the counter slot is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the bank is small and must read as zero after reset, so it is
    // built from resettable flops rather than a RAM macro.
    if (!rst_n) begin
      for (int k = 0; k < N - 1; k++) regs[k] <= '0;
    end else if (commit && !eff_is_cnt) begin
      for (int k = 0; k < N - 1; k++) begin
        if (eff_addr == ADDR_WIDTH'(k)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (eff_strb[b]) regs[k][b*8 +: 8] <= eff_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Completed-write counter; counts OKAY commits, including all-zero strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wr_count <= '0;
    else if (commit && !eff_is_cnt) wr_count <= wr_count + DATA_WIDTH'(1);
  end

  // ---------------------------------------------------------------------------
  // Read path.
  // ---------------------------------------------------------------------------
  // Read mux over current (pre-edge) contents, so a read racing a commit
  // returns the old value.
  always_comb begin
    rd_word = wr_count;
    for (int k = 0; k < N - 1; k++) begin
      if (s_araddr == ADDR_WIDTH'(k)) rd_word = regs[k];
    end
  end

  // Read data register: load on AR handshake, hold until the master takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
    end else if (rvalid_q && s_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Flatten the read/write registers onto the live output bus.
  for (genvar g = 0; g < N - 1; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Directed testbench for axi4lite_slave_regfile with a transaction-level
// model checked against the DUT on every falling edge.
module tb_axi4lite_slave_regfile;

  localparam int AW  = 2;
  localparam int DW  = 8;
  localparam int TMO = 50;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   s_awaddr;
  logic            s_awvalid;
  logic            s_awready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wvalid;
  logic            s_wready;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready;
  logic [AW-1:0]   s_araddr;
  logic            s_arvalid;
  logic            s_arready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rvalid;
  logic            s_rready;
  logic [3*DW-1:0] reg_out;

  int n_checks = 0;
  int n_errors = 0;

  axi4lite_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction model: pending AW/W halves as queues, one outstanding response
  // per channel, register array and write count as plain variables.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] m_awq[$];
  logic [DW-1:0] m_wq[$];
  logic          m_sq[$];
  logic [DW-1:0] m_regs [3];
  logic [DW-1:0] m_cnt;
  logic          m_bvalid, m_rvalid;
  logic [1:0]    m_bresp;
  logic [DW-1:0] m_rdata;
  logic          e_awready, e_wready, e_arready;

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return (a == 2'd3) ? m_cnt : m_regs[a];
  endfunction

  // Outputs are compared on the falling edge; then the model applies what
  // the next rising edge will do given the inputs now on the bus.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_awq.delete(); m_wq.delete(); m_sq.delete();
      for (int i = 0; i < 3; i++) m_regs[i] = '0;
      m_cnt = '0; m_bvalid = 1'b0; m_bresp = 2'b00; m_rvalid = 1'b0; m_rdata = '0;
    end
    e_awready = (m_awq.size() == 0) && !m_bvalid;
    e_wready  = (m_wq.size() == 0) && !m_bvalid;
    e_arready = !m_rvalid;
    check("m_awready", s_awready, e_awready);
    check("m_wready",  s_wready,  e_wready);
    check("m_arready", s_arready, e_arready);
    check("m_bvalid",  s_bvalid,  m_bvalid);
    check("m_rvalid",  s_rvalid,  m_rvalid);
    check("m_rdata",   s_rdata,   m_rdata);
    check("m_rresp",   s_rresp,   2'b00);
    check("m_reg_out", reg_out,   {m_regs[2], m_regs[1], m_regs[0]});
    if (m_bvalid) check("m_bresp", s_bresp, m_bresp);
    if (rst_n) begin
      if (m_rvalid && s_rready) m_rvalid = 1'b0;
      if (s_arvalid && e_arready) begin
        m_rdata  = model_read(s_araddr);
        m_rvalid = 1'b1;
      end
      if (m_bvalid && s_bready) m_bvalid = 1'b0;
      if (s_awvalid && e_awready) m_awq.push_back(s_awaddr);
      if (s_wvalid && e_wready) begin
        m_wq.push_back(s_wdata);
        m_sq.push_back(s_wstrb[0]);
      end
      if (m_awq.size() > 0 && m_wq.size() > 0) begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          s;
        a = m_awq.pop_front();
        d = m_wq.pop_front();
        s = m_sq.pop_front();
        if (a == 2'd3) begin
          m_bresp = 2'b10;
        end else begin
          if (s) m_regs[a] = d;
          m_cnt   = m_cnt + 8'd1;
          m_bresp = 2'b00;
        end
        m_bvalid = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers: every task starts and ends just after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic aw_send(input logic [AW-1:0] a);
    int n = 0;
    s_awaddr = a; s_awvalid = 1'b1;
    @(negedge clk);
    while (!s_awready && n < TMO) begin @(negedge clk); n++; end
    check("aw_timeout", s_awready, 1);
    sync();
    s_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic s);
    int n = 0;
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    @(negedge clk);
    while (!s_wready && n < TMO) begin @(negedge clk); n++; end
    check("w_timeout", s_wready, 1);
    sync();
    s_wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [AW-1:0] a);
    int n = 0;
    s_araddr = a; s_arvalid = 1'b1;
    @(negedge clk);
    while (!s_arready && n < TMO) begin @(negedge clk); n++; end
    check("ar_timeout", s_arready, 1);
    sync();
    s_arvalid = 1'b0;
  endtask

  // Wait for the write response (bready high); expects it one cycle after
  // the final handshake.
  task automatic wait_b(output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    while (!s_bvalid && n < TMO) begin @(negedge clk); n++; end
    check("b_timeout", s_bvalid, 1);
    check("b_latency", n, 0);
    resp = s_bresp;
    sync();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic s, output logic [1:0] resp);
    fork
      aw_send(a);
      w_send(d, s);
    join
    wait_b(resp);
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    int n = 0;
    ar_send(a);
    @(negedge clk);
    while (!s_rvalid && n < TMO) begin @(negedge clk); n++; end
    check("r_timeout", s_rvalid, 1);
    check("r_latency", n, 0);
    check("rresp", s_rresp, 2'b00);
    d = s_rdata;
    sync();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    resp;
    logic [DW-1:0] rd;

    rst_n = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b1;
    s_araddr = '0; s_arvalid = 1'b0;
    s_rready = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_bvalid",  s_bvalid,  0);
    check("rst_rvalid",  s_rvalid,  0);
    check("rst_rdata",   s_rdata,   0);
    check("rst_reg_out", reg_out,   0);
    check("rst_awready", s_awready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: simultaneous AW/W to addr 2, response for exactly one cycle.
    do_write(2'd2, 8'h04, 1'b1, resp);
    check("s1_bresp", resp, 2'b00);
    @(negedge clk);
    check("s1_bvalid_one_cycle", s_bvalid, 0);
    check("s1_reg2", reg_out[23:16], 8'h04);
    sync();
    do_read(2'd2, rd);
    check("s1_read2", rd, 8'h04);

    // 2a: W three cycles before AW.
    fork
      w_send(8'hA5, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("s2a_wready_low", s_wready, 0);
        check("s2a_no_early_b", s_bvalid, 0);
        aw_send(2'd0);
      end
    join
    wait_b(resp);
    check("s2a_bresp", resp, 2'b00);
    check("s2a_reg0", reg_out[7:0], 8'hA5);

    // 2b: AW two cycles before W.
    fork
      aw_send(2'd0);
      begin
        repeat (2) @(posedge clk);
        #1;
        check("s2b_awready_low", s_awready, 0);
        w_send(8'h5A, 1'b1);
      end
    join
    wait_b(resp);
    check("s2b_reg0", reg_out[7:0], 8'h5A);

    // 3: write to the counter slot is rejected; counter shows three writes.
    do_write(2'd3, 8'hFF, 1'b1, resp);
    check("s3_bresp_slverr", resp, 2'b10);
    check("s3_regs_unchanged", reg_out, 24'h04005A);
    do_read(2'd3, rd);
    check("s3_count", rd, 8'h03);

    // 4: bready held low; response stable, no new AW accepted.
    s_bready = 1'b0;
    fork
      aw_send(2'd2);
      w_send(8'h11, 1'b1);
    join
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s4_bvalid_hold", s_bvalid, 1);
      check("s4_bresp_hold", s_bresp, 2'b00);
      check("s4_awready_low", s_awready, 0);
      check("s4_wready_low", s_wready, 0);
    end
    sync();
    s_awaddr = 2'd2; s_awvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("s4_aw_blocked", s_awready, 0);
      check("s4_bvalid_hold2", s_bvalid, 1);
    end
    sync();
    s_bready = 1'b1;
    fork
      aw_send(2'd2);
      w_send(8'h22, 1'b1);
    join
    wait_b(resp);
    check("s4_reg2", reg_out[23:16], 8'h22);

    // 4b: rready held low; read data stable, kept after the handshake.
    s_rready = 1'b0;
    ar_send(2'd2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s4_rvalid_hold", s_rvalid, 1);
      check("s4_rdata_hold", s_rdata, 8'h22);
      check("s4_arready_low", s_arready, 0);
    end
    sync();
    s_rready = 1'b1;
    sync();
    @(negedge clk);
    check("s4_rvalid_clear", s_rvalid, 0);
    check("s4_rdata_kept", s_rdata, 8'h22);
    sync();

    // 5: read racing a commit to the same address returns the old value.
    fork
      aw_send(2'd1);
      w_send(8'h33, 1'b1);
      ar_send(2'd1);
    join
    @(negedge clk);
    check("s5_bvalid", s_bvalid, 1);
    check("s5_bresp", s_bresp, 2'b00);
    check("s5_rvalid", s_rvalid, 1);
    check("s5_rdata_old", s_rdata, 8'h00);
    sync();
    do_read(2'd1, rd);
    check("s5_read_new", rd, 8'h33);

    // 5b: all-zero strobe leaves data but still counts; racing counter read.
    fork
      aw_send(2'd0);
      w_send(8'hFF, 1'b0);
      ar_send(2'd3);
    join
    @(negedge clk);
    check("s5b_cnt_pre", s_rdata, 8'h06);
    sync();
    check("s5b_reg0_kept", reg_out[7:0], 8'h5A);
    do_read(2'd3, rd);
    check("s5b_cnt_post", rd, 8'h07);

    // 6: from reset, 256 OKAY writes wrap the counter to zero.
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("s6_rst_reg_out", reg_out, 0);
    sync();
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d8;
      d8 = i[7:0];
      do_write(AW'(i % 3), d8, 1'b1, resp);
      check("s6_bresp", resp, 2'b00);
    end
    check("s6_regs", reg_out, 24'hFEFDFF);
    do_read(2'd3, rd);
    check("s6_count_wrap", rd, 8'h00);

    // 6b: reset after AW only discards the half-written transaction.
    aw_send(2'd1);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s6b_no_bvalid", s_bvalid, 0);
      check("s6b_regs_zero", reg_out, 0);
    end
    sync();
    rst_n = 1'b1;
    w_send(8'h66, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s6b_stale_aw_gone", s_bvalid, 0);
    end
    sync();
    aw_send(2'd1);
    wait_b(resp);
    check("s6b_bresp", resp, 2'b00);
    do_read(2'd1, rd);
    check("s6b_read1", rd, 8'h66);
    do_read(2'd3, rd);
    check("s6b_count", rd, 8'h01);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi4lite_slave_regfile.md
Name: axi4lite_slave_regfile

Overview:
AXI4-Lite slave register bank; the downstream consumer of the AXI4-Lite master transactions issued by the top-level write/read engine. It implements 2**ADDR_WIDTH word registers. Registers 0..N-2 are read/write; the top register N-1 is a read-only count of completed writes. It accepts AW and W in any order, provides valid/ready back-pressure and returns OKAY/SLVERR responses.

Parameters:
ADDR_WIDTH, 2, word address width; N = 2**ADDR_WIDTH registers.
DATA_WIDTH, 8, register and bus data width; must be a multiple of 8.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_awaddr  input  ADDR_WIDTH  write address (word index)
s_awvalid  input  1  write address valid
s_awready  output  1  write address ready
s_wdata  input  DATA_WIDTH  write data
s_wstrb  input  DATA_WIDTH/8  byte strobes
s_wvalid  input  1  write data valid
s_wready  output  1  write data ready
s_bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
s_bvalid  output  1  write response valid
s_bready  input  1  write response ready
s_araddr  input  ADDR_WIDTH  read address
s_arvalid  input  1  read address valid
s_arready  output  1  read address ready
s_rdata  output  DATA_WIDTH  read data
s_rresp  output  2  read response, always 2'b00
s_rvalid  output  1  read data valid
s_rready  input  1  read data ready
reg_out  output  (N-1)*DATA_WIDTH  live contents of registers 0..N-2; register k at bits [k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (asynchronous, rst_n=0): all registers = 0, write counter = 0, aw_held = 0, w_held = 0, bvalid = 0, bresp = 0, rvalid = 0, rdata = 0, rresp = 0. Any transaction in flight is discarded; no response is issued after reset.
- Write path, with internal flags aw_held and w_held:
  - s_awready = !aw_held && !s_bvalid; s_wready = !w_held && !s_bvalid (combinational).
  - AW handshake latches awaddr and sets aw_held. W handshake latches wdata/wstrb and sets w_held.
  - Commit edge: a rising edge where (aw_held or AW handshake) and (w_held or W handshake) hold. AW and W may complete on the same edge, or on separate edges in either order.
  - At commit, if addr < N-1: bytes with wstrb=1 are updated, bresp = OKAY, and the write counter increments (including when wstrb is all-zero).
  - At commit, if addr = N-1: no register change, counter unchanged, bresp = SLVERR.
  - At commit: s_bvalid = 1, both flags clear. Response therefore appears in the cycle after the final handshake.
  - s_bvalid and s_bresp are held stable until s_bready=1; cleared on that edge. While s_bvalid is high, no new AW/W is accepted. Minimum write issue interval is 2 cycles with bready tied high.
- Read path:
  - s_arready = !s_rvalid.
  - On AR handshake, the next edge loads s_rdata = reg[araddr] (addr N-1 returns the counter), s_rresp = OKAY, s_rvalid = 1.
  - s_rdata is held stable until s_rready; s_rvalid clears on that edge. s_rdata keeps its last value afterwards.
- Read and write paths are fully independent and may handshake in the same cycle.
- AR handshake on the same edge as a write commit to the same address: the read returns the pre-write value. The counter read returns the pre-increment value.
- Write counter: DATA_WIDTH bits; wraps from 2**DATA_WIDTH-1 to 0.
- reg_out updates on the commit edge.
- No combinational path from any *valid input to any *ready output.

Test Plan:
1. Reset, then AW(addr=2) and W(data=8'h04, strb=1) together, bready=1 -> bvalid high for exactly 1 cycle, one cycle after the handshake, bresp=00; reg_out[23:16]=8'h04; a read of addr 2 returns 8'h04, rresp=00.
2. W(8'hA5) presented 3 cycles before AW(addr=0) -> wready drops after the W handshake; commit occurs only at the AW handshake; reg0=8'hA5. Repeat with AW first and W 2 cycles later, data 8'h5A -> reg0=8'h5A.
3. Write to addr 3 with data 8'hFF -> bresp=10, regs unchanged; counter read after scenarios 1-2 (three OKAY writes) returns 8'h03.
4. Hold bready=0 for 5 cycles after a write -> bvalid and bresp stable throughout; awready/wready low; a second AW is accepted only after the bready handshake. Same check with rready=0 for 4 cycles: rvalid and rdata stable.
5. Issue AR(addr=1) on the same edge as a write commit of 8'h33 to addr 1 (old value 8'h00) -> rdata=8'h00; a subsequent read returns 8'h33.
6. Perform 256 OKAY writes -> counter reads 8'h00 (wrap). Assert rst_n low mid-write, after AW only -> bvalid never asserts, all regs 0; after release, a fresh write completes normally.
